// File: rtl/au_scheduler_pkg.sv
// Shared definitions for the arithmetic-unit scheduler: unit opcodes and FSM states.
package au_scheduler_pkg;

  // Opcodes understood by the shared arithmetic unit (2'b10 is forwarded unchanged)
  localparam logic [1:0] AU_OP_ADD = 2'b00;
  localparam logic [1:0] AU_OP_SUB = 2'b01;
  localparam logic [1:0] AU_OP_SLT = 2'b11;

  // Width of each per-requester grant counter in the statistics build
  localparam int STAT_CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/au_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr,
// wrapping to 0. Works for any NREQ, power of two or not. Reusable by other
// shared resources.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  // Two passes: first requester at/above ptr, otherwise first requester from 0 (wrap)
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = IDW'(i);
        any       = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i]) begin
        grant[i]  = 1'b1;
        grant_idx = IDW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/au_scheduler.sv
// Round-robin scheduler sharing one combinational ADD/SUB/SLT unit among NREQ
// requesters. IDLE grants and latches operands, EXEC captures the unit result,
// RESP presents it to the owner until consumed.
// Optional statistics counters are enabled by defining AU_SCHED_STATS_EN.
module au_scheduler
  import au_scheduler_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_src0,
  input  logic [NREQ*N-1:0] req_src1,
  input  logic [NREQ*2-1:0] req_op,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [N-1:0]      resp_result,
  output logic [N-1:0]      au_src0,
  output logic [N-1:0]      au_src1,
  output logic [1:0]        au_op,
  input  logic [N-1:0]      au_result
`ifdef AU_SCHED_STATS_EN
  ,
  output logic [NREQ*STAT_CNT_W-1:0] grant_cnt,
  output logic [31:0]                busy_cnt
`endif
);

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [N-1:0]      src0_q, src0_d;
  logic [N-1:0]      src1_q, src1_d;
  logic [1:0]        op_q, op_d;
  logic [N-1:0]      result_q, result_d;
  logic [NREQ-1:0]   resp_valid_q, resp_valid_d;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              grant_any;
  logic              accept;
  logic              consume;
  logic [N-1:0]      sel_src0;
  logic [N-1:0]      sel_src1;
  logic [1:0]        sel_op;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Select the winner's operands from the packed request buses
  always_comb begin
    sel_src0 = '0;
    sel_src1 = '0;
    sel_op   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_src0 = req_src0[i*N +: N];
        sel_src1 = req_src1[i*N +: N];
        sel_op   = req_op[i*2 +: 2];
      end
    end
  end

  assign accept  = (state_q == S_IDLE) && grant_any;
  // Only the owner's resp_ready matters: resp_valid_q is one-hot on the owner
  assign consume = |(resp_ready & resp_valid_q);

  // Grants are visible only in IDLE; gating with rstn keeps req_ready low while reset is held
  assign req_ready   = (accept && rstn) ? grant : '0;
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign au_src0     = src0_q;
  assign au_src1     = src1_q;
  assign au_op       = op_q;

  // FSM next-state and datapath next-values
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    src0_d       = src0_q;
    src1_d       = src1_q;
    op_d         = op_q;
    result_d     = result_q;
    resp_valid_d = resp_valid_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          src0_d  = sel_src0;
          src1_d  = sel_src1;
          op_d    = sel_op;
          owner_d = grant_idx;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = au_result;
        for (int i = 0; i < NREQ; i++) begin
          resp_valid_d[i] = (owner_q == IDW'(i));
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (consume) begin
          resp_valid_d = '0;
          ptr_d        = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, pointer, owner and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: operand and result registers are reset too, because they drive
      // au_* and resp_result directly and must read zero out of reset.
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      src0_q       <= '0;
      src1_q       <= '0;
      op_q         <= '0;
      result_q     <= '0;
      resp_valid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      src0_q       <= src0_d;
      src1_q       <= src1_d;
      op_q         <= op_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
    end
  end

`ifdef AU_SCHED_STATS_EN
  logic [NREQ*STAT_CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]                busy_cnt_q, busy_cnt_d;

  // Saturating per-requester grant counters and a wrapping busy-cycle counter
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (accept && grant[i] && (grant_cnt_q[i*STAT_CNT_W +: STAT_CNT_W] != '1)) begin
        grant_cnt_d[i*STAT_CNT_W +: STAT_CNT_W] =
          grant_cnt_q[i*STAT_CNT_W +: STAT_CNT_W] + STAT_CNT_W'(1);
      end
    end
    busy_cnt_d = (state_q != S_IDLE) ? busy_cnt_q + 32'd1 : busy_cnt_q;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_cnt_q <= '0;
      busy_cnt_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign busy_cnt  = busy_cnt_q;
`endif

endmodule

// File: tb/tb_au_scheduler.sv
// Directed self-checking bench for au_scheduler (NREQ=2, N=32). A behavioural
// ADD/SUB/SLT unit is modelled here and connected to the au_* ports.
module tb_au_scheduler;
  import au_scheduler_pkg::*;

  localparam int N    = 32;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk;
  logic              rstn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_src0;
  logic [NREQ*N-1:0] req_src1;
  logic [NREQ*2-1:0] req_op;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [N-1:0]      resp_result;
  logic [N-1:0]      au_src0;
  logic [N-1:0]      au_src1;
  logic [1:0]        au_op;
  logic [N-1:0]      au_result;
`ifdef AU_SCHED_STATS_EN
  logic [NREQ*STAT_CNT_W-1:0] grant_cnt;
  logic [31:0]                busy_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  au_scheduler #(
    .N    (N),
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_src0    (req_src0),
    .req_src1    (req_src1),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .au_src0     (au_src0),
    .au_src1     (au_src1),
    .au_op       (au_op),
    .au_result   (au_result)
`ifdef AU_SCHED_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .busy_cnt    (busy_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared arithmetic unit model
  always_comb begin
    case (au_op)
      AU_OP_ADD: au_result = au_src0 + au_src1;
      AU_OP_SUB: au_result = au_src0 - au_src1;
      AU_OP_SLT: au_result = {31'd0, ($signed(au_src0) < $signed(au_src1))};
      default:   au_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int r, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [1:0] op);
    req_src0[r*N +: N] = a;
    req_src1[r*N +: N] = b;
    req_op[r*2 +: 2]   = op;
  endtask

  // One isolated operation from requester r with resp_ready high; entered and left at a negedge in IDLE
  task automatic run_single(input string tag, input int r, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic [1:0] op,
                            input logic [N-1:0] exp);
    logic [NREQ-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    load(r, a, b, op);
    req_valid = oh;
    #1;
    check({tag, "/req_ready"}, req_ready, oh);
    @(negedge clk);
    req_valid = '0;
    check({tag, "/exec_src0"}, au_src0, a);
    check({tag, "/exec_src1"}, au_src1, b);
    check({tag, "/exec_op"}, au_op, op);
    check({tag, "/exec_no_resp"}, resp_valid, 0);
    @(negedge clk);
    check({tag, "/resp_valid"}, resp_valid, oh);
    check({tag, "/resp_result"}, resp_result, exp);
    @(negedge clk);
    check({tag, "/idle_no_resp"}, resp_valid, 0);
  endtask

  initial begin
    logic [NREQ-1:0] oh;
    rstn       = 1'b1;
    req_valid  = '0;
    req_src0   = '0;
    req_src1   = '0;
    req_op     = '0;
    resp_ready = '0;
    #2 rstn = 1'b0;
    req_valid = 2'b11;

    // Reset state, with requests pending that must not be granted
    @(negedge clk);
    check("rst/req_ready", req_ready, 0);
    check("rst/resp_valid", resp_valid, 0);
    check("rst/resp_result", resp_result, 0);
    check("rst/au_src0", au_src0, 0);
    check("rst/au_src1", au_src1, 0);
    check("rst/au_op", au_op, 0);
    req_valid  = '0;
    rstn       = 1'b1;
    resp_ready = '1;
    @(negedge clk);

    // Single operations
    run_single("add", 0, 32'd5, 32'd7, AU_OP_ADD, 32'h0000000C);
    run_single("sub", 1, 32'd3, 32'd5, AU_OP_SUB, 32'hFFFFFFFE);
    run_single("slt_neg", 1, 32'hFFFFFFFF, 32'h00000001, AU_OP_SLT, 32'h00000001);
    run_single("slt_ovf", 1, 32'h7FFFFFFF, 32'h80000000, AU_OP_SLT, 32'h00000000);

    // Contention: both valid, pointer at 0 -> grants 0,1,0,1
    load(0, 32'd1, 32'd2, AU_OP_ADD);
    load(1, 32'd10, 32'd4, AU_OP_SUB);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check($sformatf("cont%0d/req_ready", k), req_ready, oh);
      @(negedge clk);
      check($sformatf("cont%0d/exec_no_grant", k), req_ready, 0);
      check($sformatf("cont%0d/exec_src0", k), au_src0, (k % 2 == 0) ? 32'd1 : 32'd10);
      @(negedge clk);
      check($sformatf("cont%0d/resp_valid", k), resp_valid, oh);
      check($sformatf("cont%0d/resp_no_grant", k), req_ready, 0);
      check($sformatf("cont%0d/resp_result", k), resp_result, (k % 2 == 0) ? 32'd3 : 32'd6);
      @(negedge clk);
    end

    // Backpressure: req 0 wins, owner holds resp_ready low for 4 cycles
    resp_ready = '0;
    #1;
    check("bp/req_ready", req_ready, 2'b01);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d/resp_valid", k), resp_valid, 2'b01);
      check($sformatf("bp%0d/resp_result", k), resp_result, 32'd3);
      check($sformatf("bp%0d/no_grant", k), req_ready, 0);
    end
    resp_ready = 2'b10;
    @(negedge clk);
    check("bp/non_owner_ignored", resp_valid, 2'b01);
    resp_ready = 2'b01;
    @(negedge clk);
    check("bp/released", resp_valid, 0);
    check("bp/next_grant_rr", req_ready, 2'b10);
    resp_ready = '1;

    // Reset in EXEC: in-flight op for req 1 is discarded
    @(negedge clk);
    check("rstx/exec_src0", au_src0, 32'd10);
    check("rstx/exec_op", au_op, AU_OP_SUB);
    rstn = 1'b0;
    #1;
    check("rstx/resp_valid", resp_valid, 0);
    check("rstx/resp_result", resp_result, 0);
    check("rstx/au_src0", au_src0, 0);
    check("rstx/au_src1", au_src1, 0);
    check("rstx/au_op", au_op, 0);
    check("rstx/req_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rstx/no_stale_resp", resp_valid, 0);
    @(negedge clk);
    check("rstx/no_stale_resp2", resp_valid, 0);
    check("rstx/result_zero", resp_result, 0);
    load(0, 32'd9, 32'd9, 2'b10);
    req_valid = 2'b11;
    #1;
    check("rstx/ptr_zero", req_ready, 2'b01);

    // Opcode 10 is forwarded unchanged to the unit
    @(negedge clk);
    req_valid = '0;
    check("op10/au_op", au_op, 2'b10);
    check("op10/au_src0", au_src0, 32'd9);
    @(negedge clk);
    check("op10/resp_valid", resp_valid, 2'b01);
    @(negedge clk);
    check("op10/idle", resp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
